// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the arbitrated register bank.
package reg_bank_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_e;

  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] onehot(
    input int unsigned idx
  );
    onehot = '0;
    onehot[idx[4:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// Round-robin pick: first asserted request at or after rr_ptr.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               any
);

  // Scan from the far end so the nearest match wins.
  always_comb begin
    int idx;
    idx = 0;
    winner_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) winner_idx = PTR_W'(idx);
    end
  end

  assign any = |req;
  assign gnt_onehot = any ?
    NUM_REQ'(onehot(32'(winner_idx))) : '0;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by several writers, one write per cycle,
// round-robin with optional burst lock.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      owned,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [WIDTH-1:0]   bank [NUM_REGS];

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_winner;
  logic               arb_any;

  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_ok;
  logic               rd_ok;
  logic [PTR_W-1:0]   ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (arb_gnt),
    .winner_idx (arb_winner),
    .any        (arb_any)
  );

  always_comb begin
    gnt    = '0;
    wr_en  = 1'b0;
    wr_idx = '0;
    if (!reset || clear) begin
      gnt = '0;
    end else if (state == IDLE) begin
      gnt    = arb_gnt;
      wr_en  = arb_any;
      wr_idx = arb_winner;
    end else if (req[owner]) begin
      gnt    = NUM_REQ'(onehot(32'(owner)));
      wr_en  = 1'b1;
      wr_idx = owner;
    end
  end

  assign wr_addr = req_addr[32'(wr_idx)*ADDR_W +: ADDR_W];
  assign wr_data = req_data[32'(wr_idx)*WIDTH +: WIDTH];

  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part
      assign wr_ok = wr_addr < ADDR_W'(NUM_REGS);
      assign rd_ok = rd_addr < ADDR_W'(NUM_REGS);
    end
  endgenerate

  assign ptr_next = (arb_winner == PTR_W'(NUM_REQ - 1)) ?
    '0 : arb_winner + PTR_W'(1);

  assign rd_data = rd_ok ? bank[rd_addr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owned  <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (clear) begin
      state <= IDLE;
      owned <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      if (wr_en && wr_ok) bank[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (arb_any) begin
            rr_ptr <= ptr_next;
            if (req_lock[arb_winner]) begin
              owner <= arb_winner;
              state <= OWNED;
              owned <= 1'b1;
            end
          end
        end
        OWNED: begin
          if (!(req[owner] && req_lock[owner])) begin
            state <= IDLE;
            owned <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          owned <= 1'b0;
        end
      endcase
    end
  end

endmodule
